// File: rtl/seq_step_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_step_monitor_if
//  Brief    : Sample/result bundle between the 0..5 counter tap and the
//             step monitor. The master supplies samples and observes results;
//             the slave (the monitor) consumes samples and drives results.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_step_monitor_if #(
    parameter int LAP_W = 8,
    parameter int ERR_W = 4
);
    logic             en;
    logic [3:0]       num_in;
    logic [1:0]       mode;
    logic             locked;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;
    logic [LAP_W-1:0] lap_cnt;
    logic [6:0]       seg;

    modport master (
        output en,
        output num_in,
        input  mode,
        input  locked,
        input  step_err,
        input  err_cnt,
        input  lap_cnt,
        input  seg
    );

    modport slave (
        input  en,
        input  num_in,
        output mode,
        output locked,
        output step_err,
        output err_cnt,
        output lap_cnt,
        output seg
    );
endinterface
`default_nettype wire

// File: rtl/seq_step_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : seq_step_monitor
//  Brief    : Watches the 0..5 dual-sequence counter. Classifies every
//             enabled sample as a linear step, shuffle step, hold at 0 or an
//             illegal step; tracks the stepping mode, counts laps (legal
//             arrivals at 0) and errors, and drives a 7-segment image of the
//             last sample. All outputs are registered (1-clock latency).
//  Revision : 1.0  initial release
// ============================================================================
module seq_step_monitor #(
    parameter int LAP_W = 8,
    parameter int ERR_W = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    seq_step_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // no valid previous sample
        ST_SYNC    = 2'd1,   // previous sample valid, mode unknown
        ST_LINEAR  = 2'd2,
        ST_SHUFFLE = 2'd3
    } state_t;

    localparam logic [1:0]       c_MODE_NONE = 2'd0;
    localparam logic [1:0]       c_MODE_LIN  = 2'd1;
    localparam logic [1:0]       c_MODE_SHF  = 2'd2;
    localparam logic [ERR_W-1:0] c_ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [6:0]       c_SEG_BLANK = 7'b0000000;
    localparam logic [6:0]       c_SEG_DASH  = 7'b1000000;

    state_t           r_state;
    logic [2:0]       r_prev;
    logic [1:0]       r_mode;
    logic             r_locked;
    logic             r_step_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic [LAP_W-1:0] r_lap_cnt;
    logic [6:0]       r_seg;

    logic             w_legal;
    logic [2:0]       w_cur;
    logic [2:0]       w_lin_next;
    logic [2:0]       w_shf_next;
    logic             w_is_lin;
    logic             w_is_shf;
    logic             w_is_hold;
    logic             w_is_lap;
    logic [ERR_W-1:0] w_err_inc;
    logic [6:0]       w_seg;

    // Only 0..5 exist upstream; the low three bits are the value when legal.
    assign w_legal = (bus.num_in <= 4'd5);
    assign w_cur   = bus.num_in[2:0];

    // Expected next value for each of the two upstream sequences.
    always_comb begin
        w_lin_next = 3'd0;
        w_shf_next = 3'd0;
        case (r_prev)
            3'd0: begin w_lin_next = 3'd1; w_shf_next = 3'd3; end
            3'd1: begin w_lin_next = 3'd2; w_shf_next = 3'd5; end
            3'd2: begin w_lin_next = 3'd3; w_shf_next = 3'd0; end
            3'd3: begin w_lin_next = 3'd4; w_shf_next = 3'd1; end
            3'd4: begin w_lin_next = 3'd5; w_shf_next = 3'd2; end
            3'd5: begin w_lin_next = 3'd0; w_shf_next = 3'd4; end
            default: begin w_lin_next = 3'd0; w_shf_next = 3'd0; end
        endcase
    end

    // The successor sets are disjoint, and hold (0->0) matches neither, so
    // at most one of these is ever true.
    assign w_is_lin  = w_legal && (w_cur == w_lin_next);
    assign w_is_shf  = w_legal && (w_cur == w_shf_next);
    assign w_is_hold = w_legal && (w_cur == 3'd0) && (r_prev == 3'd0);

    // A lap completes on a real step into 0 of either sequence.
    assign w_is_lap  = (w_is_lin || w_is_shf) && (w_cur == 3'd0);

    assign w_err_inc = (r_err_cnt == c_ERR_MAX) ? r_err_cnt
                                                : r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};

    // Segment image {g,f,e,d,c,b,a}; anything outside 0..5 shows a dash.
    always_comb begin
        w_seg = c_SEG_DASH;
        case (bus.num_in)
            4'd0:    w_seg = 7'b0111111;
            4'd1:    w_seg = 7'b0000110;
            4'd2:    w_seg = 7'b1011011;
            4'd3:    w_seg = 7'b1001111;
            4'd4:    w_seg = 7'b1100110;
            4'd5:    w_seg = 7'b1101101;
            default: w_seg = c_SEG_DASH;
        endcase
    end

    // Classification FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_prev     <= 3'd0;
            r_mode     <= c_MODE_NONE;
            r_locked   <= 1'b0;
            r_step_err <= 1'b0;
            r_err_cnt  <= {ERR_W{1'b0}};
            r_lap_cnt  <= {LAP_W{1'b0}};
            r_seg      <= c_SEG_BLANK;
        end else if (!bus.en) begin
            // Frozen: only the error pulse is allowed to fall.
            r_step_err <= 1'b0;
        end else begin
            r_seg      <= w_seg;
            r_step_err <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_legal) begin
                    r_state <= ST_SYNC;
                    r_prev  <= w_cur;
                end else begin
                    r_step_err <= 1'b1;
                    r_err_cnt  <= w_err_inc;
                    r_mode     <= c_MODE_NONE;
                    r_locked   <= 1'b0;
                end
            end else if (w_is_lin) begin
                r_state  <= ST_LINEAR;
                r_mode   <= c_MODE_LIN;
                r_locked <= 1'b1;
                r_prev   <= w_cur;
                if (w_is_lap)
                    r_lap_cnt <= r_lap_cnt + {{(LAP_W-1){1'b0}}, 1'b1};
            end else if (w_is_shf) begin
                r_state  <= ST_SHUFFLE;
                r_mode   <= c_MODE_SHF;
                r_locked <= 1'b1;
                r_prev   <= w_cur;
                if (w_is_lap)
                    r_lap_cnt <= r_lap_cnt + {{(LAP_W-1){1'b0}}, 1'b1};
            end else if (w_is_hold) begin
                // Upstream parked at 0: state, mode and prev stay as they are.
                r_state <= r_state;
            end else begin
                // Broken step: resynchronise on the new value if it is usable.
                r_step_err <= 1'b1;
                r_err_cnt  <= w_err_inc;
                r_mode     <= c_MODE_NONE;
                r_locked   <= 1'b0;
                if (w_legal) begin
                    r_state <= ST_SYNC;
                    r_prev  <= w_cur;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign bus.mode     = r_mode;
    assign bus.locked   = r_locked;
    assign bus.step_err = r_step_err;
    assign bus.err_cnt  = r_err_cnt;
    assign bus.lap_cnt  = r_lap_cnt;
    assign bus.seg      = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seq_step_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_step_monitor
//  Brief    : Directed, table-driven bench for seq_step_monitor with a few
//             hand-written multi-cycle sequences (saturation, hold, reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_step_monitor;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] SD = 7'b1000000;
    localparam logic [6:0] BL = 7'b0000000;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] num;
        logic [1:0] mode;
        logic       locked;
        logic       perr;
        logic [3:0] ec;
        logic [7:0] lap;
        logic [6:0] seg;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    vec_t tbl[$];
    logic [6:0] segtab [0:5];

    seq_step_monitor_if #(.LAP_W(8), .ERR_W(4)) bus ();

    seq_step_monitor #(.LAP_W(8), .ERR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [3:0] n,
                       input logic [1:0] m, input logic lk, input logic pe,
                       input logic [3:0] ec, input logic [7:0] lap, input logic [6:0] sg);
        vec_t v;
        v.rst_n = r; v.en = e; v.num = n; v.mode = m; v.locked = lk;
        v.perr = pe; v.ec = ec; v.lap = lap; v.seg = sg;
        tbl.push_back(v);
    endtask

    task automatic run_vec(input logic r, input logic e, input logic [3:0] n,
                           input logic [1:0] m, input logic lk, input logic pe,
                           input logic [3:0] ec, input logic [7:0] lap,
                           input logic [6:0] sg, input string name);
        @(negedge clk);
        reset      = r;
        bus.en     = e;
        bus.num_in = n;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.mode !== m || bus.locked !== lk || bus.step_err !== pe ||
            bus.err_cnt !== ec || bus.lap_cnt !== lap || bus.seg !== sg) begin
            n_miss++;
            $display("FAIL %s (num_in=%0d): got mode=%0d locked=%0d step_err=%0d err_cnt=%0d lap_cnt=%0d seg=%b; want mode=%0d locked=%0d step_err=%0d err_cnt=%0d lap_cnt=%0d seg=%b",
                     name, n, bus.mode, bus.locked, bus.step_err, bus.err_cnt,
                     bus.lap_cnt, bus.seg, m, lk, pe, ec, lap, sg);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        reset      = 1'b0;
        bus.en     = 1'b0;
        bus.num_in = 4'd0;
        segtab[0] = S0; segtab[1] = S1; segtab[2] = S2;
        segtab[3] = S3; segtab[4] = S4; segtab[5] = S5;

        // ---- reset state ----
        add(0,0,0, 0,0,0,0,0,BL);
        // ---- linear stream 0..5,0,1 ----
        add(1,1,0, 0,0,0,0,0,S0);
        add(1,1,1, 1,1,0,0,0,S1);
        add(1,1,2, 1,1,0,0,0,S2);
        add(1,1,3, 1,1,0,0,0,S3);
        add(1,1,4, 1,1,0,0,0,S4);
        add(1,1,5, 1,1,0,0,0,S5);
        add(1,1,0, 1,1,0,0,1,S0);
        add(1,1,1, 1,1,0,0,1,S1);
        // reset wins over en
        add(0,1,3, 0,0,0,0,0,BL);
        // ---- shuffle stream, two laps ----
        add(1,1,0, 0,0,0,0,0,S0);
        add(1,1,3, 2,1,0,0,0,S3);
        add(1,1,1, 2,1,0,0,0,S1);
        add(1,1,5, 2,1,0,0,0,S5);
        add(1,1,4, 2,1,0,0,0,S4);
        add(1,1,2, 2,1,0,0,0,S2);
        add(1,1,0, 2,1,0,0,1,S0);
        add(1,1,3, 2,1,0,0,1,S3);
        add(1,1,1, 2,1,0,0,1,S1);
        add(1,1,5, 2,1,0,0,1,S5);
        add(1,1,4, 2,1,0,0,1,S4);
        add(1,1,2, 2,1,0,0,1,S2);
        add(1,1,0, 2,1,0,0,2,S0);
        add(0,0,0, 0,0,0,0,0,BL);
        // ---- mixed: lin, shf, lin(lap), shf, lin ----
        add(1,1,0, 0,0,0,0,0,S0);
        add(1,1,1, 1,1,0,0,0,S1);
        add(1,1,5, 2,1,0,0,0,S5);
        add(1,1,0, 1,1,0,0,1,S0);
        add(1,1,3, 2,1,0,0,1,S3);
        add(1,1,4, 1,1,0,0,1,S4);
        add(0,0,0, 0,0,0,0,0,BL);
        // ---- illegal step, illegal value, resync ----
        add(1,1,0, 0,0,0,0,0,S0);
        add(1,1,1, 1,1,0,0,0,S1);
        add(1,1,3, 0,0,1,1,0,S3);
        add(1,1,7, 0,0,1,2,0,SD);
        add(1,1,2, 0,0,0,2,0,S2);
        add(1,1,3, 1,1,0,2,0,S3);
        // ---- freeze 5 cycles with num_in moving ----
        add(1,0,9, 1,1,0,2,0,S3);
        add(1,0,0, 1,1,0,2,0,S3);
        add(1,0,5, 1,1,0,2,0,S3);
        add(1,0,2, 1,1,0,2,0,S3);
        add(1,0,4, 1,1,0,2,0,S3);
        // classified against prev=3, so 4 is a linear step
        add(1,1,4, 1,1,0,2,0,S4);
        // error pulse then freeze: pulse drops, rest holds
        add(1,1,9, 0,0,1,3,0,SD);
        add(1,0,0, 0,0,0,3,0,SD);
        add(1,1,0, 0,0,0,3,0,S0);

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i].rst_n, tbl[i].en, tbl[i].num, tbl[i].mode, tbl[i].locked,
                    tbl[i].perr, tbl[i].ec, tbl[i].lap, tbl[i].seg, $sformatf("vec%0d", i));

        // ---- error counter saturation: 20 illegal values ----
        run_vec(0,0,0, 0,0,0,0,0,BL, "sat_reset");
        for (int i = 0; i < 20; i++) begin
            logic [3:0] exp_ec;
            logic [3:0] val;
            exp_ec = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            val    = 4'(6 + (i % 10));
            run_vec(1,1,val, 0,0,1,exp_ec,0,SD, "sat");
        end
        run_vec(1,1,0, 0,0,0,15,0,S0, "sat_recover");

        // ---- three linear laps, holds, then reset mid-lap ----
        run_vec(0,0,0, 0,0,0,0,0,BL, "hold_reset");
        run_vec(1,1,0, 0,0,0,0,0,S0, "hold_first0");
        for (int lap = 1; lap <= 3; lap++) begin
            for (int v = 1; v <= 5; v++)
                run_vec(1,1,4'(v), 1,1,0,0,8'(lap-1),segtab[v], "lap_step");
            run_vec(1,1,0, 1,1,0,0,8'(lap),S0, "lap_end");
        end
        for (int h = 0; h < 3; h++)
            run_vec(1,1,0, 1,1,0,0,3,S0, "hold0");
        run_vec(1,1,1, 1,1,0,0,3,S1, "midlap1");
        run_vec(1,1,2, 1,1,0,0,3,S2, "midlap2");
        run_vec(0,1,3, 0,0,0,0,0,BL, "midlap_reset");
        run_vec(1,1,0, 0,0,0,0,0,S0, "post_reset0");
        run_vec(1,1,3, 2,1,0,0,0,S3, "post_reset3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
